// File: rtl/run_status_monitor.sv
// -----------------------------------------------------------------------------
// run_status_monitor
//
// End-of-run checker that sits downstream of the RISC-V pipeline. It watches
// the memory-stage store interface and the writeback retire strobe and
// reaches a registered verdict (pass / fail / timeout). It also freezes its
// cycle, retired-instruction and store counters at the moment of the verdict,
// so CPI can be read afterwards.
//
// Parameters:
//   PASS_ADDR      store address that signals success together with PASS_DATA
//   PASS_DATA      data value required at PASS_ADDR
//   IGNORE_ADDR    scratch address; stores here never change the verdict
//   TIMEOUT_CYCLES run-cycle budget, 0 disables the timeout
//   CNT_W          width of all counters
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset (0 = in reset)
//   restart      in   synchronous pulse: clear counters/verdict, re-enter RUN
//   MemWriteM    in   store-valid strobe from the memory stage
//   DataAdrM     in   store address
//   WriteDataM   in   store data
//   RetireW      in   one instruction retired this cycle
//   done         out  verdict reached (any state other than RUN)
//   pass         out  success store observed
//   fail         out  illegal store observed
//   timeout      out  budget exhausted without a verdict
//   cycle_count  out  cycles spent in RUN
//   instr_count  out  instructions retired while in RUN
//   store_count  out  stores observed while in RUN (terminal store included)
//   fail_addr    out  address of the first illegal store
//   fail_data    out  data of the first illegal store
// -----------------------------------------------------------------------------
module run_status_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] IGNORE_ADDR    = 32'd96,
  parameter int unsigned TIMEOUT_CYCLES = 39,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             MemWriteM,
  input  logic [31:0]      DataAdrM,
  input  logic [31:0]      WriteDataM,
  input  logic             RetireW,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] store_count,
  output logic [31:0]      fail_addr,
  output logic [31:0]      fail_data
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // The timeout fires while the counter still shows the last budget cycle,
  // so that the increment on the leaving edge lands exactly on the budget.
  localparam bit              TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]  store_q, store_d;
  logic [31:0]       fail_addr_q, fail_addr_d;
  logic [31:0]       fail_data_q, fail_data_d;

  // Store qualification. An unknown strobe resolves to "no store" in the
  // if-statements below, so it can never produce a false FAIL.
  logic store_valid;
  logic store_is_pass;
  logic store_is_ignore;
  logic budget_last;

  always_comb begin
    store_valid     = 1'b0;
    if (MemWriteM) begin
      store_valid = 1'b1;
    end
    store_is_pass   = (DataAdrM == PASS_ADDR) && (WriteDataM == PASS_DATA);
    store_is_ignore = (DataAdrM == IGNORE_ADDR);
    budget_last     = TIMEOUT_EN && (cycle_q == TIMEOUT_LAST);
  end

  // Next-state logic for the verdict FSM.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      // Stores are evaluated before the budget so that a store on the last
      // budget cycle still decides the verdict.
      if (store_valid) begin
        if (store_is_pass) begin
          state_d = ST_PASS;
        end else if (store_is_ignore) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FAIL;
        end
      end else if (budget_last) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // Counter next-state. Counting happens on every edge that starts in RUN,
  // including the edge that leaves RUN, so the terminal cycle is included.
  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    store_d = store_q;
    if (restart) begin
      cycle_d = '0;
      instr_d = '0;
      store_d = '0;
    end else if (state_q == ST_RUN) begin
      cycle_d = cycle_q + CNT_ONE;
      if (RetireW) begin
        instr_d = instr_q + CNT_ONE;
      end
      if (store_valid) begin
        store_d = store_q + CNT_ONE;
      end
    end
  end

  // Capture of the first illegal store. Only the RUN -> FAIL transition
  // loads these; afterwards they hold until reset or restart.
  always_comb begin
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (restart) begin
      fail_addr_d = '0;
      fail_data_d = '0;
    end else if ((state_q == ST_RUN) && store_valid &&
                 !store_is_pass && !store_is_ignore) begin
      fail_addr_d = DataAdrM;
      fail_data_d = WriteDataM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      cycle_q     <= '0;
      instr_q     <= '0;
      store_q     <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      store_q     <= store_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  // Verdict flags are a direct decode of the state register; the states are
  // mutually exclusive so at most one flag is ever high.
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);
  assign timeout     = (state_q == ST_TIMEOUT);
  assign done        = (state_q != ST_RUN);
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign store_count = store_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_run_status_monitor.sv
module tb_run_status_monitor;

  logic        clk;
  logic        reset;
  logic        restart;
  logic        MemWriteM;
  logic [31:0] DataAdrM;
  logic [31:0] WriteDataM;
  logic        RetireW;

  // Instance with the default 39-cycle budget.
  logic        done, pass, fail, timeout;
  logic [31:0] cycle_count, instr_count, store_count, fail_addr, fail_data;

  // Instance with the timeout disabled; shares all inputs.
  logic        n_done, n_pass, n_fail, n_timeout;
  logic [31:0] n_cycle_count, n_instr_count, n_store_count, n_fail_addr, n_fail_data;

  int checks_cnt;
  int errors_cnt;

  run_status_monitor #(.TIMEOUT_CYCLES(39)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .MemWriteM(MemWriteM), .DataAdrM(DataAdrM), .WriteDataM(WriteDataM),
    .RetireW(RetireW),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .cycle_count(cycle_count), .instr_count(instr_count),
    .store_count(store_count), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  run_status_monitor #(.TIMEOUT_CYCLES(0)) dut_nto (
    .clk(clk), .reset(reset), .restart(restart),
    .MemWriteM(MemWriteM), .DataAdrM(DataAdrM), .WriteDataM(WriteDataM),
    .RetireW(RetireW),
    .done(n_done), .pass(n_pass), .fail(n_fail), .timeout(n_timeout),
    .cycle_count(n_cycle_count), .instr_count(n_instr_count),
    .store_count(n_store_count), .fail_addr(n_fail_addr), .fail_data(n_fail_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end else begin
      $display("chk  %s = %0d", tag, got);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one RUN cycle of pipeline activity, then advance.
  task automatic cyc(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic ret);
    MemWriteM  = we;
    DataAdrM   = adr;
    WriteDataM = dat;
    RetireW    = ret;
    step();
    MemWriteM  = 1'b0;
    RetireW    = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset      = 1'b0;
    restart    = 1'b0;
    MemWriteM  = 1'b0;
    DataAdrM   = '0;
    WriteDataM = '0;
    RetireW    = 1'b0;

    // Reset state.
    step();
    step();
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cycle", cycle_count, 32'd0);
    check("rst_faddr", fail_addr, 32'd0);
    reset = 1'b1;

    // Pass run: scratch store at cycle 10, pass store at cycle 20.
    for (int k = 0; k <= 20; k++) begin
      if (k == 10)      cyc(1'b1, 32'd96, 32'd7, 1'b1);
      else if (k == 20) cyc(1'b1, 32'd100, 32'd25, 1'b1);
      else              cyc(1'b0, 32'd0, 32'd0, 1'b1);
      if (k == 10) check("pass_scratch_done", {31'd0, done}, 32'd0);
    end
    check("pass_pass", {31'd0, pass}, 32'd1);
    check("pass_done", {31'd0, done}, 32'd1);
    check("pass_cycle", cycle_count, 32'd21);
    check("pass_instr", instr_count, 32'd21);
    check("pass_store", store_count, 32'd2);
    cyc(1'b1, 32'd104, 32'd3, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 1'b1);
    check("pass_frozen_cycle", cycle_count, 32'd21);
    check("pass_frozen_instr", instr_count, 32'd21);
    check("pass_sticky_fail", {31'd0, fail}, 32'd0);

    // Fail run: illegal store at cycle 5, then a pass store that must be ignored.
    do_restart();
    check("rs_cycle", cycle_count, 32'd0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 32'd0, 32'd0, 1'b1);
    cyc(1'b1, 32'd104, 32'd3, 1'b1);
    check("fail_fail", {31'd0, fail}, 32'd1);
    check("fail_addr", fail_addr, 32'd104);
    check("fail_data", fail_data, 32'd3);
    check("fail_cycle", cycle_count, 32'd6);
    cyc(1'b1, 32'd100, 32'd25, 1'b1);
    check("fail_late_pass", {31'd0, pass}, 32'd0);
    check("fail_sticky", {31'd0, fail}, 32'd1);
    check("fail_store", store_count, 32'd1);

    // Restart in FAIL with a concurrent illegal store: restart wins.
    MemWriteM = 1'b1; DataAdrM = 32'd200; WriteDataM = 32'd9; RetireW = 1'b1;
    do_restart();
    MemWriteM = 1'b0; RetireW = 1'b0;
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_cycle", cycle_count, 32'd0);
    check("restart_instr", instr_count, 32'd0);
    check("restart_store", store_count, 32'd0);
    check("restart_faddr", fail_addr, 32'd0);
    check("restart_fdata", fail_data, 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1);
    check("resume_cycle", cycle_count, 32'd1);
    check("resume_instr", instr_count, 32'd1);

    // Wrong data at the pass address.
    cyc(1'b1, 32'd100, 32'd24, 1'b0);
    check("wdata_fail", {31'd0, fail}, 32'd1);
    check("wdata_pass", {31'd0, pass}, 32'd0);
    check("wdata_fdata", fail_data, 32'd24);
    check("wdata_faddr", fail_addr, 32'd100);
    check("wdata_cycle", cycle_count, 32'd2);

    // Timeout run: no stores, budget of 39 cycles.
    do_restart();
    for (int k = 0; k < 38; k++) cyc(1'b0, 32'd0, 32'd0, 1'b0);
    check("to_early_done", {31'd0, done}, 32'd0);
    check("to_early_cycle", cycle_count, 32'd38);
    cyc(1'b0, 32'd0, 32'd0, 1'b0);
    check("to_timeout", {31'd0, timeout}, 32'd1);
    check("to_done", {31'd0, done}, 32'd1);
    check("to_cycle", cycle_count, 32'd39);
    check("to_instr", instr_count, 32'd0);

    // Pass store on the last budget cycle beats timeout.
    do_restart();
    for (int k = 0; k < 38; k++) cyc(1'b0, 32'd0, 32'd0, 1'b0);
    cyc(1'b1, 32'd100, 32'd25, 1'b0);
    check("edge_pass", {31'd0, pass}, 32'd1);
    check("edge_timeout", {31'd0, timeout}, 32'd0);
    check("edge_cycle", cycle_count, 32'd39);
    check("edge_store", store_count, 32'd1);

    // Disabled timeout: 100 idle cycles.
    do_restart();
    for (int k = 0; k < 100; k++) cyc(1'b0, 32'd0, 32'd0, 1'b0);
    check("nto_done", {31'd0, n_done}, 32'd0);
    check("nto_cycle", n_cycle_count, 32'd100);
    check("nto_ref_timeout", {31'd0, timeout}, 32'd1);
    check("nto_ref_cycle", cycle_count, 32'd39);

    // Asynchronous reset mid-cycle after a FAIL verdict.
    do_restart();
    for (int k = 0; k < 5; k++) cyc(1'b0, 32'd0, 32'd0, 1'b1);
    cyc(1'b1, 32'd104, 32'd3, 1'b1);
    check("ar_pre_fail", {31'd0, fail}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("ar_fail", {31'd0, fail}, 32'd0);
    check("ar_done", {31'd0, done}, 32'd0);
    check("ar_cycle", cycle_count, 32'd0);
    check("ar_instr", instr_count, 32'd0);
    check("ar_faddr", fail_addr, 32'd0);
    check("ar_nto_cycle", n_cycle_count, 32'd0);
    step();
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
